// File: rtl/pc_predict.sv
// pc_predict: fetch-stage PC register with a direct-mapped BTB and 2-bit
// saturating direction counters. Fetch follows predicted-taken entries; an
// Execute-stage resolution trains the BTB and, when the fetch-time guess was
// wrong, redirects the PC and raises a same-cycle flush.
module pc_predict #(
  parameter int              WIDTH       = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             res_valid_i,
  input  logic [WIDTH-1:0] res_pc_i,
  input  logic             res_taken_i,
  input  logic             res_jump_i,
  input  logic [WIDTH-1:0] res_target_i,
  input  logic             res_pred_taken_i,
  input  logic [WIDTH-1:0] res_pred_target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             pred_taken_o,
  output logic [WIDTH-1:0] pred_target_o,
  output logic             flush_o,
  output logic [31:0]      mispredict_cnt_o
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  // Architectural state
  logic [WIDTH-1:0]       pc_reg;
  logic [WIDTH-1:0]       pc_next;
  logic [31:0]            cnt_reg;

  // BTB storage: valid bits are reset, payload fields are plain storage
  logic [BTB_ENTRIES-1:0] valid_reg;
  logic [BTB_ENTRIES-1:0] jump_reg;
  logic [TAG_W-1:0]       tag_reg    [BTB_ENTRIES];
  logic [WIDTH-1:0]       target_reg [BTB_ENTRIES];
  logic [1:0]             ctr_reg    [BTB_ENTRIES];

  // Lookup side (fetch PC)
  logic [IDX-1:0]         lk_idx;
  logic [TAG_W-1:0]       lk_tag;
  logic                   lk_hit;
  logic [WIDTH-1:0]       pc_plus4;
  logic                   pred_taken;
  logic [WIDTH-1:0]       pred_target;

  // Update side (resolved PC)
  logic [IDX-1:0]         up_idx;
  logic [TAG_W-1:0]       up_tag;
  logic                   up_hit;
  logic                   upd_we;
  logic [BTB_ENTRIES-1:0] wr_en;
  logic [WIDTH-1:0]       ent_target_next;
  logic                   ent_jump_next;
  logic [1:0]             ent_ctr_next;

  logic                   mispredict;
  logic [WIDTH-1:0]       redirect_pc;

  // PCs are word aligned; the low two bits never select anything
  logic unused_low_bits;
  assign unused_low_bits = ^{res_pc_i[1:0], pc_reg[1:0]};

  // ---------------- lookup ----------------
  assign lk_idx      = pc_reg[IDX+1:2];
  assign lk_tag      = pc_reg[WIDTH-1:IDX+2];
  assign lk_hit      = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
  assign pc_plus4    = pc_reg + WIDTH'(4);
  assign pred_taken  = lk_hit && (jump_reg[lk_idx] || ctr_reg[lk_idx][1]);
  assign pred_target = pred_taken ? target_reg[lk_idx] : pc_plus4;

  // ---------------- resolution ----------------
  assign mispredict  = res_valid_i &&
                       ((res_taken_i != res_pred_taken_i) ||
                        (res_taken_i && (res_target_i != res_pred_target_i)));
  assign redirect_pc = res_taken_i ? res_target_i : (res_pc_i + WIDTH'(4));

  assign up_idx = res_pc_i[IDX+1:2];
  assign up_tag = res_pc_i[WIDTH-1:IDX+2];
  assign up_hit = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);

  // Decide whether the indexed entry is written and what it becomes
  always_comb begin
    upd_we          = 1'b0;
    ent_target_next = target_reg[up_idx];
    ent_jump_next   = jump_reg[up_idx];
    ent_ctr_next    = ctr_reg[up_idx];
    if (res_valid_i) begin
      if (up_hit) begin
        upd_we = 1'b1;
        if (res_jump_i) begin
          ent_target_next = res_target_i;
          ent_jump_next   = 1'b1;
        end else if (res_taken_i) begin
          ent_target_next = res_target_i;
          if (ctr_reg[up_idx] != 2'd3) ent_ctr_next = ctr_reg[up_idx] + 2'd1;
        end else begin
          // entry stays valid even once the counter bottoms out
          if (ctr_reg[up_idx] != 2'd0) ent_ctr_next = ctr_reg[up_idx] - 2'd1;
        end
      end else if (res_taken_i) begin
        // allocate (or evict an alias) starting at weak taken
        upd_we          = 1'b1;
        ent_target_next = res_target_i;
        ent_jump_next   = res_jump_i;
        ent_ctr_next    = 2'd2;
      end
    end
  end

  // One-hot entry write enables
  generate
    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_wr_en
      assign wr_en[gi] = upd_we && (up_idx == IDX'(gi));
    end
  endgenerate

  // Next-PC priority: redirect beats stall, stall beats prediction
  always_comb begin
    pc_next = pred_target;
    if (mispredict)   pc_next = redirect_pc;
    else if (stall_i) pc_next = pc_reg;
  end

  // PC register and saturating mispredict counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg  <= RESET_PC;
      cnt_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (mispredict && (cnt_reg != 32'hFFFF_FFFF)) cnt_reg <= cnt_reg + 32'd1;
    end
  end

  // Valid bits: cleared by reset, set by any entry write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_reg <= '0;
    else        valid_reg <= valid_reg | wr_en;
  end

  // BTB payload writes; lookup sees the new contents from the next cycle on
  always_ff @(posedge clk) begin
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (wr_en[i]) begin
        tag_reg[i]    <= up_tag;
        target_reg[i] <= ent_target_next;
        jump_reg[i]   <= ent_jump_next;
        ctr_reg[i]    <= ent_ctr_next;
      end
    end
  end

  assign pc_o             = pc_reg;
  assign pc_plus4_o       = pc_plus4;
  assign pred_taken_o     = pred_taken;
  assign pred_target_o    = pred_target;
  assign flush_o          = mispredict;
  assign mispredict_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pc_predict.sv
// Bench for pc_predict: directed scenarios with known answers, then a long
// randomized run against a behavioural BTB/PC model.
module tb_pc_predict;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        res_valid_i;
  logic [31:0] res_pc_i;
  logic        res_taken_i;
  logic        res_jump_i;
  logic [31:0] res_target_i;
  logic        res_pred_taken_i;
  logic [31:0] res_pred_target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        flush_o;
  logic [31:0] mispredict_cnt_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  pc_predict #(.WIDTH(32), .BTB_ENTRIES(N), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_jump_i(res_jump_i), .res_target_i(res_target_i),
    .res_pred_taken_i(res_pred_taken_i), .res_pred_target_i(res_pred_target_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .pred_taken_o(pred_taken_o),
    .pred_target_o(pred_target_o), .flush_o(flush_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic set_idle();
    stall_i = 1'b0; res_valid_i = 1'b0; res_pc_i = '0; res_taken_i = 1'b0;
    res_jump_i = 1'b0; res_target_i = '0; res_pred_taken_i = 1'b0; res_pred_target_i = '0;
  endtask

  task automatic drive_res(input logic [31:0] pc, input logic taken, input logic jump,
                           input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    res_valid_i = 1'b1; res_pc_i = pc; res_taken_i = taken; res_jump_i = jump;
    res_target_i = tgt; res_pred_taken_i = ptaken; res_pred_target_i = ptgt;
    $display("res pc=%h taken=%0d jump=%0d tgt=%h pred=%0d/%h", pc, taken, jump, tgt, ptaken, ptgt);
  endtask

  task automatic cycle_idle();
    @(negedge clk); set_idle(); #1;
  endtask

  task automatic cycle_res(input logic [31:0] pc, input logic taken, input logic jump,
                           input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    @(negedge clk); set_idle(); drive_res(pc, taken, jump, tgt, ptaken, ptgt); #1;
  endtask

  // Forces fetch to addr via a not-taken resolution that was predicted taken
  task automatic redirect_to(input logic [31:0] addr);
    cycle_res(addr - 32'd4, 1'b0, 1'b0, 32'h0, 1'b1, 32'h99);
    exp_cnt = exp_cnt + 32'd1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; set_idle();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
    n_cmp++; if (pc_plus4_o !== 32'h4) begin n_bad++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4_o, 32'h4); end
    n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL reset_pred got=%b exp=0", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h4) begin n_bad++; $display("FAIL reset_ptgt got=%h exp=%h", pred_target_o, 32'h4); end
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
    n_cmp++; if (mispredict_cnt_o !== 32'h0) begin n_bad++; $display("FAIL reset_cnt got=%h exp=0", mispredict_cnt_o); end
    rst_n = 1'b1;
    exp_cnt = 32'h0;
    $display("reset released");
  endtask

  task automatic test_free_run();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cycle_idle();
      $display("free run pc=%h", pc_o);
      n_cmp++; if (pc_o !== 32'(4 * k)) begin n_bad++; $display("FAIL free_pc got=%h exp=%h", pc_o, 32'(4 * k)); end
      n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL free_pred got=%b exp=0", pred_taken_o); end
      n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL free_flush got=%b exp=0", flush_o); end
    end
  endtask

  task automatic test_train();
    cycle_res(32'h10, 1'b1, 1'b0, 32'h40, 1'b0, 32'h14); exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL alloc_flush got=%b exp=1", flush_o); end
    cycle_idle();
    n_cmp++; if (pc_o !== 32'h40) begin n_bad++; $display("FAIL alloc_redirect got=%h exp=%h", pc_o, 32'h40); end
    n_cmp++; if (mispredict_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL alloc_cnt got=%0d exp=%0d", mispredict_cnt_o, exp_cnt); end
    redirect_to(32'h10); cycle_idle();
    n_cmp++; if (pc_o !== 32'h10) begin n_bad++; $display("FAIL train_pc got=%h exp=%h", pc_o, 32'h10); end
    n_cmp++; if (pred_taken_o !== 1'b1) begin n_bad++; $display("FAIL train_pred got=%b exp=1", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h40) begin n_bad++; $display("FAIL train_ptgt got=%h exp=%h", pred_target_o, 32'h40); end
    n_cmp++; if (mispredict_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL train_cnt got=%0d exp=%0d", mispredict_cnt_o, exp_cnt); end
    // not taken twice: 2 -> 1 (mispredicted), 1 -> 0 (correct)
    cycle_res(32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40); exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL nt1_flush got=%b exp=1", flush_o); end
    cycle_idle();
    n_cmp++; if (pc_o !== 32'h14) begin n_bad++; $display("FAIL nt1_redirect got=%h exp=%h", pc_o, 32'h14); end
    cycle_res(32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 32'h14);
    n_cmp++; if (flush_o !== 1'b0) begin n_bad++; $display("FAIL nt2_flush got=%b exp=0", flush_o); end
    redirect_to(32'h10); cycle_idle();
    n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL nt2_pred got=%b exp=0", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h14) begin n_bad++; $display("FAIL nt2_ptgt got=%h exp=%h", pred_target_o, 32'h14); end
  endtask

  task automatic test_jalr();
    cycle_res(32'h20, 1'b1, 1'b1, 32'h84, 1'b1, 32'h80); exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL jalr_flush got=%b exp=1", flush_o); end
    cycle_idle();
    n_cmp++; if (pc_o !== 32'h84) begin n_bad++; $display("FAIL jalr_redirect got=%h exp=%h", pc_o, 32'h84); end
    redirect_to(32'h20); cycle_idle();
    n_cmp++; if (pred_taken_o !== 1'b1) begin n_bad++; $display("FAIL jalr_pred got=%b exp=1", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h84) begin n_bad++; $display("FAIL jalr_ptgt got=%h exp=%h", pred_target_o, 32'h84); end
  endtask

  task automatic test_alias();
    // retrain 0x10 (currently ctr 0) up to weak taken with a new target
    cycle_res(32'h10, 1'b1, 1'b0, 32'h44, 1'b0, 32'h14); exp_cnt = exp_cnt + 32'd1;
    cycle_res(32'h10, 1'b1, 1'b0, 32'h44, 1'b0, 32'h14); exp_cnt = exp_cnt + 32'd1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL retrain_flush got=%b exp=1", flush_o); end
    redirect_to(32'h10); cycle_idle();
    n_cmp++; if (pred_taken_o !== 1'b1) begin n_bad++; $display("FAIL retrain_pred got=%b exp=1", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h44) begin n_bad++; $display("FAIL retrain_ptgt got=%h exp=%h", pred_target_o, 32'h44); end
    cycle_res(32'h50, 1'b1, 1'b0, 32'h200, 1'b0, 32'h54); exp_cnt = exp_cnt + 32'd1;
    cycle_idle();
    n_cmp++; if (pc_o !== 32'h200) begin n_bad++; $display("FAIL alias_redirect got=%h exp=%h", pc_o, 32'h200); end
    redirect_to(32'h10); cycle_idle();
    n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL alias_evict got=%b exp=0", pred_taken_o); end
    redirect_to(32'h50); cycle_idle();
    n_cmp++; if (pred_taken_o !== 1'b1) begin n_bad++; $display("FAIL alias_new_pred got=%b exp=1", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h200) begin n_bad++; $display("FAIL alias_new_ptgt got=%h exp=%h", pred_target_o, 32'h200); end
  endtask

  task automatic test_stall();
    // fetch at 0x50 predicts 0x200; stall must hold it
    stall_i = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (pc_o !== 32'h50) begin n_bad++; $display("FAIL stall_hold got=%h exp=%h", pc_o, 32'h50); end
    drive_res(32'h100, 1'b1, 1'b0, 32'h300, 1'b0, 32'h104); exp_cnt = exp_cnt + 32'd1;
    #1;
    n_cmp++; if (flush_o !== 1'b1) begin n_bad++; $display("FAIL stall_flush got=%b exp=1", flush_o); end
    cycle_idle();
    n_cmp++; if (pc_o !== 32'h300) begin n_bad++; $display("FAIL stall_redirect got=%h exp=%h", pc_o, 32'h300); end
    n_cmp++; if (mispredict_cnt_o !== exp_cnt) begin n_bad++; $display("FAIL stall_cnt got=%0d exp=%0d", mispredict_cnt_o, exp_cnt); end
    redirect_to(32'h100); cycle_idle();
    n_cmp++; if (pred_taken_o !== 1'b1) begin n_bad++; $display("FAIL stall_update got=%b exp=1", pred_taken_o); end
    n_cmp++; if (pred_target_o !== 32'h300) begin n_bad++; $display("FAIL stall_update_tgt got=%h exp=%h", pred_target_o, 32'h300); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    $display("async reset asserted");
    n_cmp++; if (pc_o !== 32'h0) begin n_bad++; $display("FAIL areset_pc got=%h exp=0", pc_o); end
    n_cmp++; if (mispredict_cnt_o !== 32'h0) begin n_bad++; $display("FAIL areset_cnt got=%h exp=0", mispredict_cnt_o); end
    @(negedge clk); rst_n = 1'b1; #1;
    // walk past 0x10, 0x20, 0x50 which were all trained before reset
    for (int k = 0; k < 22; k++) begin
      if (k > 0) cycle_idle();
      n_cmp++; if (pc_o !== 32'(4 * k)) begin n_bad++; $display("FAIL areset_walk_pc got=%h exp=%h", pc_o, 32'(4 * k)); end
      n_cmp++; if (pred_taken_o !== 1'b0) begin n_bad++; $display("FAIL areset_walk_pred pc=%h got=%b exp=0", pc_o, pred_taken_o); end
    end
  endtask

  // ---------------- randomized run against a model ----------------
  typedef struct { bit v; int unsigned tag; logic [31:0] tgt; bit j; int ctr; } ent_t;

  task automatic test_random();
    ent_t        m [N];
    logic [31:0] m_pc, m_cnt, e_ptgt;
    int unsigned idx, tg;
    bit          hit, e_pt, e_mis;
    rst_n = 1'b0; set_idle();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N; i++) m[i] = '{0, 0, 32'h0, 0, 0};
    m_pc = 32'h0; m_cnt = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      set_idle();
      stall_i     = ($urandom_range(0, 3) == 0);
      res_valid_i = 1'($urandom_range(0, 1));
      if (res_valid_i) begin
        res_pc_i     = 32'($urandom_range(0, 63) * 4);
        res_jump_i   = ($urandom_range(0, 3) == 0);
        res_taken_i  = res_jump_i ? 1'b1 : 1'($urandom_range(0, 1));
        res_target_i = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 1) == 1) begin
          res_pred_taken_i  = res_taken_i;
          res_pred_target_i = res_taken_i ? res_target_i : res_pc_i + 32'd4;
        end else begin
          res_pred_taken_i  = 1'($urandom_range(0, 1));
          res_pred_target_i = 32'($urandom_range(0, 63) * 4);
        end
      end
      #1;
      // expected outputs from the model's current state
      idx    = (m_pc / 4) % N;
      tg     = m_pc / (4 * N);
      hit    = m[idx].v && (m[idx].tag == tg);
      e_pt   = hit && (m[idx].j || m[idx].ctr >= 2);
      e_ptgt = e_pt ? m[idx].tgt : m_pc + 32'd4;
      e_mis  = res_valid_i && ((res_taken_i != res_pred_taken_i) ||
                               (res_taken_i && res_target_i != res_pred_target_i));
      if (res_valid_i)
        $display("rand %0d res pc=%h taken=%0d jump=%0d tgt=%h flush=%0d", c, res_pc_i, res_taken_i, res_jump_i, res_target_i, flush_o);
      n_cmp++; if (pc_o !== m_pc) begin n_bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", c, pc_o, m_pc); end
      n_cmp++; if (pc_plus4_o !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc4 cyc=%0d got=%h exp=%h", c, pc_plus4_o, m_pc + 32'd4); end
      n_cmp++; if (pred_taken_o !== e_pt) begin n_bad++; $display("FAIL rnd_pred cyc=%0d got=%b exp=%b", c, pred_taken_o, e_pt); end
      n_cmp++; if (pred_target_o !== e_ptgt) begin n_bad++; $display("FAIL rnd_ptgt cyc=%0d got=%h exp=%h", c, pred_target_o, e_ptgt); end
      n_cmp++; if (flush_o !== e_mis) begin n_bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", c, flush_o, e_mis); end
      n_cmp++; if (mispredict_cnt_o !== m_cnt) begin n_bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, mispredict_cnt_o, m_cnt); end
      // advance the model to the next cycle
      if (e_mis)        m_pc = res_taken_i ? res_target_i : res_pc_i + 32'd4;
      else if (!stall_i) m_pc = e_ptgt;
      if (e_mis && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (res_valid_i) begin
        idx = (res_pc_i / 4) % N;
        tg  = res_pc_i / (4 * N);
        if (m[idx].v && m[idx].tag == tg) begin
          if (res_jump_i) begin
            m[idx].tgt = res_target_i; m[idx].j = 1;
          end else if (res_taken_i) begin
            m[idx].tgt = res_target_i; m[idx].ctr = (m[idx].ctr == 3) ? 3 : m[idx].ctr + 1;
          end else begin
            m[idx].ctr = (m[idx].ctr == 0) ? 0 : m[idx].ctr - 1;
          end
        end else if (res_taken_i) begin
          m[idx] = '{1, tg, res_target_i, res_jump_i, 2};
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_train();
    test_jalr();
    test_alias();
    test_stall();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
